if_fetch_unit: RTL



---
 rtl/rv32i_types.sv | 18 +
 rtl/fetch_hold_buffer.sv | 29 ++
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types for the RV32I core
package rv32i_types;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - one-entry instruction hold buffer
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  // Capture one fetched instruction; clear wins so a redirect always empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= 32'h0;
      pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        true_branch,
  input  logic [31:0] branch_pc,
  input  logic        stall,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  import rv32i_types::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  // Address of the request being drained while in DISCARD; pc_q already holds the target
  logic [31:0]  disc_addr_q, disc_addr_d;
  if_id_t       if_id_q, if_id_d;

  logic         buf_load;
  logic         buf_clear;
  logic         buf_valid;
  logic [31:0]  buf_inst;
  logic [31:0]  buf_pc;

  fetch_hold_buffer u_hold_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_inst (inst_rdata),
    .load_pc   (pc_q),
    .valid     (buf_valid),
    .inst      (buf_inst),
    .pc        (buf_pc)
  );

  // Request is held stable until its response; DISCARD keeps presenting the old address
  always_comb begin
    inst_read = ~rst & (state_q != HOLD);
    inst_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;
  end

  // State register, PC and IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      disc_addr_q <= RESET_PC;
      if_id_q     <= '{valid: 1'b0, inst: NOP_INST, pc: 32'h0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      if_id_q     <= if_id_d;
    end
  end

  // Next-state: redirect first, then response/stall handling per state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    if_id_d     = if_id_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;

    if (true_branch) begin
      pc_d         = {branch_pc[31:2], 2'b00};
      if_id_d.valid = 1'b0;
      if_id_d.inst  = NOP_INST;
      buf_clear    = 1'b1;
      unique case (state_q)
        REQ: begin
          if (inst_resp) begin
            state_d = REQ;
          end else begin
            state_d     = DISCARD;
            disc_addr_d = pc_q;
          end
        end
        HOLD:    state_d = REQ;
        DISCARD: state_d = inst_resp ? REQ : DISCARD;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (inst_resp) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              if_id_d = '{valid: 1'b1, inst: inst_rdata, pc: pc_q};
            end
          end else if (!stall) begin
            if_id_d.valid = 1'b0;
            if_id_d.inst  = NOP_INST;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_d   = '{valid: buf_valid, inst: buf_inst, pc: buf_pc};
            buf_clear = 1'b1;
            state_d   = REQ;
          end
        end
        DISCARD: begin
          if (!stall) begin
            if_id_d.valid = 1'b0;
            if_id_d.inst  = NOP_INST;
          end
          if (inst_resp) begin
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  assign if_valid = if_id_q.valid;
  assign if_inst  = if_id_q.inst;
  assign if_pc    = if_id_q.pc;

endmodule
